// File: rtl/word_2_byte_if.sv
// word_2_byte_if
// Groups the word-side and byte-side handshake signals of the word_2_byte
// serializer, together with the shared clock enable.
//   ce          : clock enable; state advances only when high
//   word_dv     : input word valid
//   word        : 16-bit input word
//   word_ready  : serializer can take a word this cycle
//   byte_dv     : byte_out holds a valid byte
//   byte_out    : current output byte
//   byte_ready  : byte sink accepts byte_out
//   overrun     : one-cycle pulse when an offered word was dropped
// Modports: master = word source / byte sink side, slave = the serializer.
interface word_2_byte_if;
    logic        ce;
    logic        word_dv;
    logic [15:0] word;
    logic        word_ready;
    logic        byte_dv;
    logic [7:0]  byte_out;
    logic        byte_ready;
    logic        overrun;

    modport master (
        output ce, word_dv, word, byte_ready,
        input  word_ready, byte_dv, byte_out, overrun
    );

    modport slave (
        input  ce, word_dv, word, byte_ready,
        output word_ready, byte_dv, byte_out, overrun
    );
endinterface

// File: rtl/word_2_byte.sv
// word_2_byte
// Serializes one 16-bit word into two bytes on a valid/ready byte port.
// The first byte sent is the one the receive-side packer places in
// word[15:8] when MSB_FIRST=1; with MSB_FIRST=0 the low byte goes first.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : word_2_byte_if.slave (ce, word/word_dv/word_ready,
//         byte_out/byte_dv/byte_ready, overrun)
// Optional build macro WORD_2_BYTE_BUF_EN adds a one-entry word buffer so
// a word offered mid-serialization is kept and sent back-to-back.
module word_2_byte #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    word_2_byte_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        overrun_q, overrun_d;
    logic        wordReady;
    logic [7:0]  firstByte;
    logic [7:0]  secondByte;

`ifdef WORD_2_BYTE_BUF_EN
    logic [15:0] buf_q, buf_d;
    logic        bufFull_q, bufFull_d;

    // Only a full buffer blocks the source; while IDLE the buffer is empty.
    assign wordReady = !bufFull_q;
`else
    assign wordReady = (state_q == IDLE);
`endif

    assign firstByte  = MSB_FIRST ? hold_q[15:8] : hold_q[7:0];
    assign secondByte = MSB_FIRST ? hold_q[7:0]  : hold_q[15:8];

    // All registers share one enable, so ce=0 freezes state, hold word,
    // buffer and the overrun pulse together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= 16'h0000;
            overrun_q <= 1'b0;
`ifdef WORD_2_BYTE_BUF_EN
            buf_q     <= 16'h0000;
            bufFull_q <= 1'b0;
`endif
        end else if (bus.ce) begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            overrun_q <= overrun_d;
`ifdef WORD_2_BYTE_BUF_EN
            buf_q     <= buf_d;
            bufFull_q <= bufFull_d;
`endif
        end
    end

    // Next-state logic, evaluated as if ce=1; the register enable above
    // discards it on ce=0 cycles.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        overrun_d = bus.word_dv && !wordReady;
`ifdef WORD_2_BYTE_BUF_EN
        buf_d     = buf_q;
        bufFull_d = bufFull_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.word_dv) begin
                    hold_d  = bus.word;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (bus.byte_ready) begin
                    state_d = SECOND;
                end
`ifdef WORD_2_BYTE_BUF_EN
                if (bus.word_dv && !bufFull_q) begin
                    buf_d     = bus.word;
                    bufFull_d = 1'b1;
                end
`endif
            end
            SECOND: begin
`ifdef WORD_2_BYTE_BUF_EN
                // On the last byte, a pending word (buffered or arriving
                // now) starts the next serialization without an idle cycle.
                if (bus.byte_ready) begin
                    if (bufFull_q) begin
                        hold_d    = buf_q;
                        bufFull_d = 1'b0;
                        state_d   = FIRST;
                    end else if (bus.word_dv) begin
                        hold_d  = bus.word;
                        state_d = FIRST;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.word_dv && !bufFull_q) begin
                    buf_d     = bus.word;
                    bufFull_d = 1'b1;
                end
`else
                if (bus.byte_ready) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Byte port outputs decode straight from the state register.
    always_comb begin
        bus.byte_out = 8'h00;
        case (state_q)
            FIRST:   bus.byte_out = firstByte;
            SECOND:  bus.byte_out = secondByte;
            default: bus.byte_out = 8'h00;
        endcase
    end

    assign bus.word_ready = wordReady;
    assign bus.byte_dv    = (state_q != IDLE);
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_word_2_byte.sv
// tb_word_2_byte
// Scoreboard bench for word_2_byte (MSB_FIRST=1). Stimulus pushes the
// bytes each word should produce; a negedge monitor pops and compares
// whenever a byte is handed over (ce && byte_dv && byte_ready).
module tb_word_2_byte;

`ifdef WORD_2_BYTE_BUF_EN
    localparam bit BufEn = 1'b1;
`else
    localparam bit BufEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    word_2_byte_if bus();

    word_2_byte #(.MSB_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         overrunSeen = 0;
    int         overrunExp = 0;
    logic [7:0] expQ[$];

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for a single cycle; optionally queue its two bytes.
    task automatic applyStimulus(input logic [15:0] w, input bit expectBytes);
        if (expectBytes) begin
            expQ.push_back(w[15:8]);
            expQ.push_back(w[7:0]);
        end
        bus.word_dv = 1'b1;
        bus.word    = w;
        tick();
        bus.word_dv = 1'b0;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while (expQ.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        checkOutput("drainPending", 16'(expQ.size()), 16'd0);
        expQ.delete();
    endtask

    // Monitor: byte handover and overrun pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.ce === 1'b1) begin
            if (bus.byte_dv === 1'b1 && bus.byte_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedByte: got %h expected none", bus.byte_out);
                end else begin
                    checkOutput("byteOut", {8'h00, bus.byte_out}, {8'h00, expQ.pop_front()});
                end
            end
            if (bus.overrun === 1'b1) begin
                overrunSeen++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus.ce         = 1'b1;
        bus.word_dv    = 1'b0;
        bus.word       = 16'h0000;
        bus.byte_ready = 1'b0;
        #2;
        checkOutput("rstByteDv", 16'(bus.byte_dv), 16'd0);
        checkOutput("rstByteOut", {8'h00, bus.byte_out}, 16'h0000);
        checkOutput("rstWordReady", 16'(bus.word_ready), 16'd1);
        checkOutput("rstOverrun", 16'(bus.overrun), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Basic: A55A with the sink always ready.
        $display("[TB] basic A55A");
        bus.byte_ready = 1'b1;
        applyStimulus(16'hA55A, 1'b1);
        checkOutput("basicReady1", 16'(bus.word_ready), 16'd0);
        checkOutput("basicDv1", 16'(bus.byte_dv), 16'd1);
        checkOutput("basicByte1", {8'h00, bus.byte_out}, 16'h00A5);
        tick();
        checkOutput("basicReady2", 16'(bus.word_ready), 16'd0);
        checkOutput("basicByte2", {8'h00, bus.byte_out}, 16'h005A);
        tick();
        checkOutput("basicReady3", 16'(bus.word_ready), 16'd1);
        checkOutput("basicDv3", 16'(bus.byte_dv), 16'd0);
        checkOutput("basicByte3", {8'h00, bus.byte_out}, 16'h0000);
        waitDrain(10);

        // Back-pressure: 1234 held for five cycles.
        $display("[TB] back-pressure 1234");
        bus.byte_ready = 1'b0;
        applyStimulus(16'h1234, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bpHoldDv", 16'(bus.byte_dv), 16'd1);
            checkOutput("bpHoldByte", {8'h00, bus.byte_out}, 16'h0012);
            tick();
        end
        checkOutput("bpHoldByteLast", {8'h00, bus.byte_out}, 16'h0012);
        bus.byte_ready = 1'b1;
        tick();
        checkOutput("bpSecond", {8'h00, bus.byte_out}, 16'h0034);
        tick();
        checkOutput("bpIdle", 16'(bus.byte_dv), 16'd0);
        waitDrain(10);

        // ce gating: BEEF with ce alternating.
        $display("[TB] ce gating BEEF");
        bus.byte_ready = 1'b1;
        bus.ce = 1'b1;
        applyStimulus(16'hBEEF, 1'b1);
        bus.ce = 1'b0;
        checkOutput("ceFirst", {8'h00, bus.byte_out}, 16'h00BE);
        tick();
        checkOutput("ceFirstFrozen", {8'h00, bus.byte_out}, 16'h00BE);
        checkOutput("ceFirstDv", 16'(bus.byte_dv), 16'd1);
        bus.ce = 1'b1;
        tick();
        bus.ce = 1'b0;
        checkOutput("ceSecond", {8'h00, bus.byte_out}, 16'h00EF);
        tick();
        checkOutput("ceSecondFrozen", {8'h00, bus.byte_out}, 16'h00EF);
        bus.ce = 1'b1;
        tick();
        checkOutput("ceDone", 16'(bus.byte_dv), 16'd0);
        bus.ce      = 1'b0;
        bus.word_dv = 1'b1;
        bus.word    = 16'hFFFF;
        tick();
        bus.word_dv = 1'b0;
        bus.ce      = 1'b1;
        checkOutput("ceIgnoredWordDv", 16'(bus.byte_dv), 16'd0);
        checkOutput("ceIgnoredReady", 16'(bus.word_ready), 16'd1);
        tick();
        checkOutput("ceIgnoredDv2", 16'(bus.byte_dv), 16'd0);
        waitDrain(10);

        // Overrun: second word offered during FIRST.
        $display("[TB] overrun 2468 then 0F0F");
        bus.byte_ready = 1'b1;
        applyStimulus(16'h2468, 1'b1);
        if (!BufEn) overrunExp++;
        applyStimulus(16'h0F0F, BufEn);
        checkOutput("ovrPulse", 16'(bus.overrun), BufEn ? 16'd0 : 16'd1);
        checkOutput("ovrSecondByte", {8'h00, bus.byte_out}, 16'h0068);
        tick();
        checkOutput("ovrPulseEnd", 16'(bus.overrun), 16'd0);
        checkOutput("ovrNextDv", 16'(bus.byte_dv), BufEn ? 16'd1 : 16'd0);
        checkOutput("ovrNextByte", {8'h00, bus.byte_out}, BufEn ? 16'h000F : 16'h0000);
        waitDrain(10);
        repeat (2) tick();

        // Word offered on the final byte_ready in SECOND.
        $display("[TB] word on final byte 1357 then 9BDF");
        applyStimulus(16'h1357, 1'b1);
        tick();
        checkOutput("simSecond", {8'h00, bus.byte_out}, 16'h0057);
        if (!BufEn) overrunExp++;
        applyStimulus(16'h9BDF, BufEn);
        checkOutput("simOverrun", 16'(bus.overrun), BufEn ? 16'd0 : 16'd1);
        checkOutput("simDv", 16'(bus.byte_dv), BufEn ? 16'd1 : 16'd0);
        checkOutput("simByte", {8'h00, bus.byte_out}, BufEn ? 16'h009B : 16'h0000);
        waitDrain(10);
        repeat (2) tick();

        // Reset in SECOND of C3D2: D2 must never be emitted.
        $display("[TB] reset mid-transfer C3D2");
        bus.byte_ready = 1'b0;
        expQ.push_back(8'hC3);
        applyStimulus(16'hC3D2, 1'b0);
        checkOutput("rstMidFirst", {8'h00, bus.byte_out}, 16'h00C3);
        bus.byte_ready = 1'b1;
        tick();
        bus.byte_ready = 1'b0;
        checkOutput("rstMidSecond", {8'h00, bus.byte_out}, 16'h00D2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstMidDv", 16'(bus.byte_dv), 16'd0);
        checkOutput("rstMidByte", {8'h00, bus.byte_out}, 16'h0000);
        checkOutput("rstMidReady", 16'(bus.word_ready), 16'd1);
        tick();
        rst = 1'b0;
        bus.byte_ready = 1'b1;
        repeat (4) tick();
        checkOutput("rstAfterDv", 16'(bus.byte_dv), 16'd0);
        waitDrain(10);

        // Loopback-style word pair.
        $display("[TB] word pair 8001 7FFE");
        applyStimulus(16'h8001, 1'b1);
        repeat (2) tick();
        applyStimulus(16'h7FFE, 1'b1);
        repeat (2) tick();
        waitDrain(10);

        repeat (3) tick();
        checkOutput("overrunCount", 16'(overrunSeen), 16'(overrunExp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
